pass_attempt_ctrl: RTL
======================

Name: pass_attempt_ctrl

Overview:
Controller placed in front of the password-checker FSM. It accepts password characters over a valid/ready handshake and forwards them one per enable pulse. It clears the checker between attempts and samples the checker's pass flag after a fixed number of characters. It counts consecutive failures, grants access for a timed window on success, and enforces a timed lockout after too many failures.

Parameters:
PASS_LEN, 5, characters per attempt (>=1)
CHECK_LAT, 2, cycles from last chk_enable pulse to sampling chk_pass_ok (>=1)
MAX_FAILS, 3, consecutive failures that trigger lockout (>=1)
GRANT_CYCLES, 50, cycles access_granted stays high (>=1)
LOCK_CYCLES, 1000, lockout duration in cycles (>=1)
TIMEOUT_CYCLES, 200, inter-character timeout (used only with the optional feature)

Ports:
clock  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
char_valid  in  1  source has a character
char_data  in  8  ASCII character
char_ready  out  1  controller accepts a character this cycle
chk_enable  out  1  one-cycle enable pulse to checker
chk_data  out  8  registered character to checker
chk_clear  out  1  synchronous reset to checker
chk_pass_ok  in  1  checker pass flag
access_granted  out  1  high during GRANT
locked  out  1  high during LOCKOUT
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failure count
attempt_done  out  1  one-cycle pulse when an attempt resolves

Behaviour:
- Reset values and control:
  - reset is synchronous, active-high; clock is clock.
  - After any reset edge: state IDLE, char count 0, fail_count 0, chk_data 0, chk_enable 0, access_granted 0, locked 0, attempt_done 0.
  - chk_clear=1 while reset is high.
  - char_ready=1, because it is combinational from state.
- Reset mid-operation: abandon the attempt, grant or lockout in that cycle; no attempt_done pulse.
- Handshake:
  - A transfer occurs when char_valid && char_ready at a rising edge.
  - char_ready=1 only in IDLE and COLLECT.
  - On transfer, chk_data<=char_data and chk_enable=1 for exactly the next cycle.
  - The source holds char_valid while ready is low; characters are never dropped or duplicated.
- States:
  - IDLE: first transfer sets char_cnt=1. If PASS_LEN==1 go to CHECK, else go to COLLECT.
  - COLLECT: each transfer increments char_cnt. The transfer that makes char_cnt==PASS_LEN goes to CHECK.
  - CHECK: char_ready=0. A latency counter starts at the cycle chk_enable is high. After CHECK_LAT cycles, sample chk_pass_ok and pulse attempt_done.
    - chk_pass_ok=1: go to GRANT.
    - chk_pass_ok=0: go to FAIL.
  - GRANT: on entry fail_count<=0. access_granted=1 for exactly GRANT_CYCLES cycles. On the last cycle chk_clear=1; then go to IDLE with char_cnt=0.
  - FAIL: single cycle. chk_clear=1, char_cnt<=0, fail_count<=fail_count+1 (saturating at MAX_FAILS).
    - New count==MAX_FAILS: go to LOCKOUT.
    - Otherwise: go to IDLE.
  - LOCKOUT: locked=1 and char_ready=0 for exactly LOCK_CYCLES cycles. On exit, fail_count<=0; go to IDLE.
- Width rule: internal counters are sized with $clog2(max+1) of their limit and never wrap.
- chk_clear is 0 in all other cycles.

Optional Feature:
- Macro PASS_CTRL_TIMEOUT_EN.
- Defined:
  - In COLLECT, an idle counter resets on every transfer and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, the partial attempt aborts: attempt_done pulses, then go to FAIL (counts as a failure).
  - The counter is inactive in IDLE.
- Undefined: COLLECT waits indefinitely; TIMEOUT_CYCLES is ignored and adds no logic.

Test Plan:
- Success path: defaults; send "T","A","U","L","E" back-to-back; checker model asserts chk_pass_ok. Required response:
  - 5 chk_enable pulses with matching chk_data.
  - attempt_done exactly 2 cycles after the 5th enable.
  - access_granted high for 50 cycles.
  - chk_clear pulse at the end, then char_ready=1.
- Failure count: send "TAULX" twice. Required response: fail_count 1 then 2, one chk_clear per attempt, locked stays 0.
- Lockout: 3 wrong attempts. Required response:
  - locked=1 and char_ready=0 for 1000 cycles; char_valid held high during lockout is not consumed.
  - fail_count returns to 0 on exit.
  - The next "TAULE" is granted.
- Success clears failures: 2 wrong attempts, then "TAULE". Required response: fail_count goes 2 -> 0 on GRANT entry.
- Backpressure and reset: char_valid toggling with gaps; assert reset after the 3rd char. Required response:
  - No duplicate or dropped enables.
  - Next cycle: state IDLE, chk_clear=1 during reset, char_cnt 0.
  - No attempt_done pulse.
- With PASS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=200: send "TA", then idle 200 cycles. Required response: attempt_done, fail_count=1, chk_clear pulse, state IDLE. Without the macro, the same stimulus stays in COLLECT.

Source files
------------

// File: rtl/pass_attempt_ctrl_if.sv
// Character handshake between the password source and pass_attempt_ctrl.
interface pass_attempt_ctrl_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/pass_attempt_ctrl.sv
// Front-end for the password checker: forwards characters, resolves attempts, grants or locks out.
// Optional macro PASS_CTRL_TIMEOUT_EN aborts a partial attempt after TIMEOUT_CYCLES idle cycles.
module pass_attempt_ctrl #(
  parameter int unsigned PASS_LEN       = 5,
  parameter int unsigned CHECK_LAT      = 2,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned GRANT_CYCLES   = 50,
  parameter int unsigned LOCK_CYCLES    = 1000
`ifdef PASS_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 200
`endif
) (
  input  logic                           clock,
  input  logic                           reset,
  pass_attempt_ctrl_if.slave             char_if,
  output logic                           chk_enable,
  output logic [7:0]                     chk_data,
  output logic                           chk_clear,
  input  logic                           chk_pass_ok,
  output logic                           access_granted,
  output logic                           locked,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic                           attempt_done
);

  localparam int unsigned CntW   = $clog2(PASS_LEN + 1);
  localparam int unsigned LatW   = $clog2(CHECK_LAT + 1);
  localparam int unsigned FailW  = $clog2(MAX_FAILS + 1);
  localparam int unsigned GrantW = $clog2(GRANT_CYCLES + 1);
  localparam int unsigned LockW  = $clog2(LOCK_CYCLES + 1);

  localparam logic [CntW-1:0]   CntPenult  = CntW'(PASS_LEN - 1);
  localparam logic [LatW-1:0]   LatLast    = LatW'(CHECK_LAT - 1);
  localparam logic [FailW-1:0]  FailMax    = FailW'(MAX_FAILS);
  localparam logic [FailW-1:0]  FailPenult = FailW'(MAX_FAILS - 1);
  localparam logic [GrantW-1:0] GrantLast  = GrantW'(GRANT_CYCLES - 1);
  localparam logic [LockW-1:0]  LockLast   = LockW'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StCollect, StCheck, StGrant, StFail, StLockout} state_e;

  state_e            state_q;
  logic [CntW-1:0]   char_cnt_q;
  logic [LatW-1:0]   lat_q;
  logic [GrantW-1:0] grant_q;
  logic [LockW-1:0]  lock_q;
  logic              ready;
  logic              xfer;

`ifdef PASS_CTRL_TIMEOUT_EN
  localparam int unsigned IdleW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  logic [IdleW-1:0]  idle_q;
`endif

  assign ready              = (state_q == StIdle) || (state_q == StCollect);
  assign char_if.char_ready = ready;
  assign xfer               = char_if.char_valid && ready;

  // Checker is cleared during reset, in FAIL and in the final GRANT cycle.
  assign chk_clear = reset || (state_q == StFail) ||
                     ((state_q == StGrant) && (grant_q == GrantLast));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      char_cnt_q     <= '0;
      lat_q          <= '0;
      grant_q        <= '0;
      lock_q         <= '0;
      fail_count     <= '0;
      chk_data       <= '0;
      chk_enable     <= 1'b0;
      access_granted <= 1'b0;
      locked         <= 1'b0;
      attempt_done   <= 1'b0;
`ifdef PASS_CTRL_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      chk_enable   <= xfer;
      attempt_done <= 1'b0;
      if (xfer) chk_data <= char_if.char_data;

      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            char_cnt_q <= CntW'(1);
            lat_q      <= '0;
            state_q    <= (PASS_LEN == 1) ? StCheck : StCollect;
`ifdef PASS_CTRL_TIMEOUT_EN
            idle_q     <= '0;
`endif
          end
        end
        StCollect: begin
          if (xfer) begin
            char_cnt_q <= char_cnt_q + 1'b1;
            lat_q      <= '0;
            if (char_cnt_q == CntPenult) state_q <= StCheck;
`ifdef PASS_CTRL_TIMEOUT_EN
            idle_q     <= '0;
          end else if (idle_q == IdleLast) begin
            attempt_done <= 1'b1;
            state_q      <= StFail;
          end else begin
            idle_q <= idle_q + 1'b1;
`endif
          end
        end
        StCheck: begin
          // lat_q counts from the cycle the final chk_enable is high
          if (lat_q == LatLast) begin
            attempt_done <= 1'b1;
            if (chk_pass_ok) begin
              state_q        <= StGrant;
              grant_q        <= '0;
              fail_count     <= '0;
              access_granted <= 1'b1;
            end else begin
              state_q <= StFail;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StGrant: begin
          if (grant_q == GrantLast) begin
            state_q        <= StIdle;
            char_cnt_q     <= '0;
            access_granted <= 1'b0;
          end else begin
            grant_q <= grant_q + 1'b1;
          end
        end
        StFail: begin
          char_cnt_q <= '0;
          if (fail_count >= FailPenult) begin
            fail_count <= FailMax;
            lock_q     <= '0;
            locked     <= 1'b1;
            state_q    <= StLockout;
          end else begin
            fail_count <= fail_count + 1'b1;
            state_q    <= StIdle;
          end
        end
        StLockout: begin
          if (lock_q == LockLast) begin
            fail_count <= '0;
            locked     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            lock_q <= lock_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
